// File: rtl/billiard_pkg.sv
// Shared types for the ball/hole pocket tracker.
// Hole id type, "any hole" code and tracker FSM states.
package billiard_pkg;

  localparam int NUM_BALLS_DEF = 2;

  typedef logic [2:0] holeId_t;

  localparam holeId_t HOLE_ANY = 3'd0;

  typedef enum logic [1:0] {
    S_COLLECT,
    S_EVAL,
    S_REPORT
  } state_t;

endpackage

// File: rtl/pocket_overlap_counter.sv
// Per-ball ball/hole overlap counter with first-hit hole latch.
// Ports: clk, resetN, clr, en, holeId in; qualify, holeLat out.
module pocket_overlap_counter
  import billiard_pkg::*;
#(
  parameter int MIN_OVERLAP = 4
) (
  input  logic    clk,
  input  logic    resetN,
  input  logic    clr,
  input  logic    en,
  input  holeId_t holeId,
  output logic    qualify,
  output holeId_t holeLat
);

  logic [7:0] cnt;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      cnt     <= '0;
      holeLat <= HOLE_ANY;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      if (cnt != 8'hFF)
        cnt <= cnt + 8'd1;
      if (cnt == 8'd0)
        holeLat <= holeId;
    end
  end

  assign qualify = (cnt >= 8'(MIN_OVERLAP));

endmodule

// File: rtl/ball_pocket_tracker.sv
// Frame-based pocket detector feeding the game controller FSM.
// In: clk, resetN, startOfFrame, ballDrawingRequest,
//  holeDrawingRequest, hole_id, request_hole, rack_reload.
// Out: balls_in_game, ballhole_collide, curr_Hole_id,
//  foulPulse. Option: POCKET_DEBOUNCE_EN (two-frame confirm).
module ball_pocket_tracker
  import billiard_pkg::*;
#(
  parameter int NUM_BALLS      = NUM_BALLS_DEF,
  parameter int MIN_OVERLAP    = 4,
  parameter int RESPAWN_FRAMES = 60
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic [NUM_BALLS:0] ballDrawingRequest,
  input  logic               holeDrawingRequest,
  input  holeId_t            hole_id,
  input  holeId_t            request_hole,
  input  logic               rack_reload,
  output logic [NUM_BALLS:0] balls_in_game,
  output logic [NUM_BALLS:0] ballhole_collide,
  output holeId_t            curr_Hole_id,
  output logic               foulPulse
);

  localparam int NB = NUM_BALLS;
  localparam int RW =
    (RESPAWN_FRAMES < 2) ? 1 : $clog2(RESPAWN_FRAMES + 1);

  state_t        state;
  logic [RW-1:0] respCnt;
  logic [NB:0]   qual;
  logic [NB:0]   cntEn;
  logic          clrCnt;
  holeId_t       holeLat  [NB+1];
  holeId_t       holeSnap [NB+1];
  logic [NB:0]   qSnap;
  logic [NB:0]   effQ;
  logic [NB:0]   legalR;
  logic [NB:0]   foulR;
  logic [NB:0]   eff;
  logic [NB:0]   legal;
  logic [NB:0]   foul;
  holeId_t       lowHole;
  logic [NB:0]   bigSet;

`ifdef POCKET_DEBOUNCE_EN
  logic [NB:0]   pend;
  holeId_t       pendHole [NB+1];
`endif

  // Frame-boundary pixels are dropped by the clear.
  assign clrCnt = rack_reload |
    ((state == S_COLLECT) & startOfFrame);

  for (genvar g = 0; g <= NB; g++) begin : gCnt
    assign cntEn[g] = ballDrawingRequest[g] &
      holeDrawingRequest & balls_in_game[g];
    pocket_overlap_counter #(
      .MIN_OVERLAP(MIN_OVERLAP)
    ) uCnt (
      .clk    (clk),
      .resetN (resetN),
      .clr    (clrCnt),
      .en     (cntEn[g]),
      .holeId (hole_id),
      .qualify(qual[g]),
      .holeLat(holeLat[g])
    );
  end

  always_comb begin
    eff     = qSnap;
`ifdef POCKET_DEBOUNCE_EN
    for (int i = 0; i <= NB; i++)
      eff[i] = qSnap[i] & pend[i] &
        (pendHole[i] == holeSnap[i]);
`endif
    legal    = '0;
    foul     = '0;
    legal[0] = eff[0];
    for (int i = 1; i <= NB; i++) begin
      legal[i] = eff[i] &
        ((request_hole == HOLE_ANY) |
         (holeSnap[i] == request_hole));
      foul[i]  = eff[i] & ~legal[i];
    end
    lowHole = curr_Hole_id;
    for (int i = NB; i >= 0; i--)
      if (eff[i])
        lowHole = holeSnap[i];
  end

  // White returns on the frame its countdown expires.
  always_comb begin
    bigSet    = '0;
    bigSet[0] = startOfFrame & ~balls_in_game[0] &
      (respCnt <= RW'(1));
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state            <= S_COLLECT;
      respCnt          <= '0;
      balls_in_game    <= '1;
      ballhole_collide <= '0;
      curr_Hole_id     <= HOLE_ANY;
      foulPulse        <= 1'b0;
      qSnap            <= '0;
      effQ             <= '0;
      legalR           <= '0;
      foulR            <= '0;
      for (int i = 0; i <= NB; i++)
        holeSnap[i] <= HOLE_ANY;
`ifdef POCKET_DEBOUNCE_EN
      pend <= '0;
      for (int i = 0; i <= NB; i++)
        pendHole[i] <= HOLE_ANY;
`endif
    end else if (rack_reload) begin
      state            <= S_COLLECT;
      respCnt          <= '0;
      balls_in_game    <= '1;
      ballhole_collide <= '0;
      foulPulse        <= 1'b0;
`ifdef POCKET_DEBOUNCE_EN
      pend <= '0;
`endif
    end else begin
      ballhole_collide <= '0;
      foulPulse        <= 1'b0;
      balls_in_game    <= balls_in_game | bigSet;
      if (startOfFrame && respCnt != '0)
        respCnt <= respCnt - RW'(1);
      unique case (state)
        S_COLLECT: begin
          if (startOfFrame) begin
            qSnap <= qual & balls_in_game;
            for (int i = 0; i <= NB; i++)
              holeSnap[i] <= holeLat[i];
            state <= S_EVAL;
          end
        end
        S_EVAL: begin
          legalR <= legal;
          foulR  <= foul;
          effQ   <= eff;
          if (|eff)
            curr_Hole_id <= lowHole;
`ifdef POCKET_DEBOUNCE_EN
          pend <= qSnap & ~eff;
          for (int i = 0; i <= NB; i++)
            pendHole[i] <= holeSnap[i];
`endif
          state <= S_REPORT;
        end
        S_REPORT: begin
          ballhole_collide <= legalR;
          foulPulse        <= |foulR;
          balls_in_game    <=
            (balls_in_game | bigSet) & ~effQ;
          if (effQ[0])
            respCnt <= RW'(RESPAWN_FRAMES);
          state <= S_COLLECT;
        end
        default: state <= S_COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_ball_pocket_tracker.sv
// Directed bench for ball_pocket_tracker.
// NUM_BALLS=2, MIN_OVERLAP=4, RESPAWN_FRAMES=3.
module tb_ball_pocket_tracker;

  logic       clk = 1'b0;
  logic       resetN;
  logic       startOfFrame;
  logic [2:0] ballDrawingRequest;
  logic       holeDrawingRequest;
  logic [2:0] hole_id;
  logic [2:0] request_hole;
  logic       rack_reload;
  logic [2:0] balls_in_game;
  logic [2:0] ballhole_collide;
  logic [2:0] curr_Hole_id;
  logic       foulPulse;

  int nTests = 0;
  int nFail  = 0;

  always #5 clk = ~clk;

  ball_pocket_tracker #(
    .NUM_BALLS     (2),
    .MIN_OVERLAP   (4),
    .RESPAWN_FRAMES(3)
  ) dut (
    .clk               (clk),
    .resetN            (resetN),
    .startOfFrame      (startOfFrame),
    .ballDrawingRequest(ballDrawingRequest),
    .holeDrawingRequest(holeDrawingRequest),
    .hole_id           (hole_id),
    .request_hole      (request_hole),
    .rack_reload       (rack_reload),
    .balls_in_game     (balls_in_game),
    .ballhole_collide  (ballhole_collide),
    .curr_Hole_id      (curr_Hole_id),
    .foulPulse         (foulPulse)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pix(input logic [2:0] mask,
                     input logic [2:0] hole,
                     input int n);
    for (int k = 0; k < n; k++) begin
      ballDrawingRequest = mask;
      holeDrawingRequest = 1'b1;
      hole_id            = hole;
      step();
    end
    ballDrawingRequest = '0;
    holeDrawingRequest = 1'b0;
    hole_id            = '0;
  endtask

  task automatic rack();
    rack_reload = 1'b1;
    step();
    rack_reload = 1'b0;
    chk("rack_big", balls_in_game, 3'b111);
    chk("rack_col", ballhole_collide, 3'b000);
  endtask

  task automatic frame(input string tag,
                       input logic [2:0] sofPix,
                       input logic [2:0] eCol,
                       input logic       eFoul,
                       input logic [2:0] eHole,
                       input logic [2:0] eBig);
    startOfFrame       = 1'b1;
    ballDrawingRequest = sofPix;
    holeDrawingRequest = |sofPix;
    hole_id            = 3'd5;
    step();
    startOfFrame       = 1'b0;
    ballDrawingRequest = '0;
    holeDrawingRequest = 1'b0;
    hole_id            = '0;
    chk({tag, "_col_e"}, ballhole_collide, 3'b000);
    step();
    chk({tag, "_col_r"}, ballhole_collide, 3'b000);
    step();
    chk({tag, "_col"}, ballhole_collide, eCol);
    chk({tag, "_foul"}, foulPulse, eFoul);
    chk({tag, "_hole"}, curr_Hole_id, eHole);
    chk({tag, "_big"}, balls_in_game, eBig);
    step();
    chk({tag, "_col_end"}, ballhole_collide, 3'b000);
    chk({tag, "_foul_end"}, foulPulse, 1'b0);
  endtask

  initial begin
    resetN             = 1'b0;
    startOfFrame       = 1'b0;
    ballDrawingRequest = '0;
    holeDrawingRequest = 1'b0;
    hole_id            = '0;
    request_hole       = '0;
    rack_reload        = 1'b0;
    #12;
    chk("rst_big", balls_in_game, 3'b111);
    chk("rst_col", ballhole_collide, 3'b000);
    chk("rst_hole", curr_Hole_id, 3'd0);
    chk("rst_foul", foulPulse, 1'b0);
    resetN = 1'b1;
    step();

    pix(3'b010, 3'd5, 4);
    frame("b1h5", 3'b000, 3'b010, 1'b0, 3'd5, 3'b101);

    pix(3'b100, 3'd3, 3);
    frame("b2short", 3'b000, 3'b000, 1'b0, 3'd5, 3'b101);
    pix(3'b100, 3'd3, 1);
    frame("b2clr", 3'b000, 3'b000, 1'b0, 3'd5, 3'b101);

    request_hole = 3'd2;
    pix(3'b100, 3'd4, 4);
    frame("foul", 3'b000, 3'b000, 1'b1, 3'd4, 3'b001);
    request_hole = 3'd0;
    rack();

    pix(3'b001, 3'd1, 4);
    frame("white", 3'b000, 3'b001, 1'b0, 3'd1, 3'b110);
    frame("resp1", 3'b000, 3'b000, 1'b0, 3'd1, 3'b110);
    frame("resp2", 3'b000, 3'b000, 1'b0, 3'd1, 3'b110);
    frame("resp3", 3'b000, 3'b000, 1'b0, 3'd1, 3'b111);

    pix(3'b001, 3'd1, 4);
    frame("white2", 3'b000, 3'b001, 1'b0, 3'd1, 3'b110);
    frame("w2f1", 3'b000, 3'b000, 1'b0, 3'd1, 3'b110);
    rack();
    for (int f = 0; f < 3; f++)
      frame("postrack", 3'b000, 3'b000, 1'b0,
            3'd1, 3'b111);

    pix(3'b010, 3'd5, 4);
    startOfFrame = 1'b1;
    step();
    startOfFrame = 1'b0;
    rack_reload  = 1'b1;
    step();
    rack_reload  = 1'b0;
    chk("rk_eval_col0", ballhole_collide, 3'b000);
    chk("rk_eval_big0", balls_in_game, 3'b111);
    step();
    chk("rk_eval_col1", ballhole_collide, 3'b000);
    step();
    chk("rk_eval_col2", ballhole_collide, 3'b000);
    chk("rk_eval_big2", balls_in_game, 3'b111);
    chk("rk_eval_hole", curr_Hole_id, 3'd1);

    pix(3'b010, 3'd5, 3);
    frame("sofpix", 3'b010, 3'b000, 1'b0, 3'd1, 3'b111);
    pix(3'b010, 3'd5, 3);
    frame("sofdrop", 3'b000, 3'b000, 1'b0, 3'd1, 3'b111);

    pix(3'b010, 3'd6, 4);
    pix(3'b100, 3'd2, 4);
    frame("both", 3'b000, 3'b110, 1'b0, 3'd6, 3'b001);

    $display("[TB] %0d tests run, %0d failed",
             nTests, nFail);
    $finish;
  end

endmodule
